// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the tt_um_uart_tx tile: FSM encoding,
// frame geometry and the fixed uio direction mask.
package tt_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int UART_DATA_BITS = 8;

  // uio[1] carries busy and uio[2] carries the tx line; every other uio pin is an input.
  localparam logic [7:0] UIO_OE_MASK = 8'b0000_0110;

  // Baud counter width, never below one bit so the counter always exists.
  function automatic int baud_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter core: FSM, baud/bit counters and shift register.
// All outputs are registered from the next-state values, so tx changes on the same edge as the state.
module uart_tx_core
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [UART_DATA_BITS-1:0] data,
  output logic                      tx,
  output logic                      busy,
  output logic                      done,
  output state_t                    state_dbg
);

  localparam int                BAUD_W    = baud_width(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  state_t                    state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      baud_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign baud_wrap = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;

    unique case (state_q)
      IDLE: begin
        // Start requests are only honoured here, so edges while busy are dropped.
        if (start) begin
          shreg_d = data;
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values follow the state being entered so they land on the same edge.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/tt_um_uart_tx.sv
// TinyTapeout tile wrapper: synchronises the send strobe, detects its rising
// edge and maps the transmitter core onto the standard tile pins.
module tt_um_uart_tx
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  logic   s1_q, s2_q, s3_q;
  logic   send_edge;
  logic   tx, busy, done;
  state_t core_state;
  logic   unused_ok;

  // s1/s2 resolve metastability on the asynchronous strobe; s3 holds the previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= uio_in[0];
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign send_edge = s2_q & ~s3_q;

  uart_tx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (send_edge),
    .data      (ui_in),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .state_dbg (core_state)
  );

  assign uo_out  = {5'b0, done, busy, tx};
  assign uio_out = {5'b0, tx, busy, 1'b0};
  assign uio_oe  = UIO_OE_MASK;

  assign unused_ok = &{1'b0, ena, uio_in[7:1], core_state};

endmodule
